// File: rtl/beam_threshold_loader_pkg.sv
// Shared widths, error codes and FSM encodings for the threshold-update receiver.
package beam_threshold_loader_pkg;

    localparam int THRESH_W = 18;
    localparam logic [THRESH_W-1:0] DEFAULT_THRESH = 18'h3FFFF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_LANE    = 2'd2,
        ERR_COLLIDE = 2'd3
    } err_code_t;

    typedef enum logic {
        ST_OK  = 1'b0,
        ST_ERR = 1'b1
    } err_state_t;

    // Beams are carried in pairs, one per lane; an odd count leaves lane1 of the last pair unused.
    function automatic int ndualbeams(input int nbeams);
        return (nbeams + 1) / 2;
    endfunction

endpackage

// File: rtl/beam_threshold_loader_if.sv
// Threshold-update stream from the controller into the loader.
interface beam_threshold_loader_if;
    import beam_threshold_loader_pkg::*;

    // No ready/backpressure: every strobe is a single-cycle command taken on the
    // clock edge it is high, data qualified by thresh_wr_i, lanes move in lockstep.
    logic [2*THRESH_W-1:0] thresh_i;
    logic [1:0]            thresh_wr_i;
    logic [1:0]            thresh_update_i;
    logic                  err_clr_i;

    modport master (
        output thresh_i,
        output thresh_wr_i,
        output thresh_update_i,
        output err_clr_i
    );

    modport slave (
        input thresh_i,
        input thresh_wr_i,
        input thresh_update_i,
        input err_clr_i
    );

endinterface

// File: rtl/beam_threshold_loader_lane.sv
// One lane: shift-register shadow chain of the incoming frame plus a saturating write counter.
module beam_threshold_loader_lane
    import beam_threshold_loader_pkg::*;
#(
    parameter int NUM_THRESH = 46,
    parameter int CNT_W      = $clog2(NUM_THRESH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             shift,
    input  logic                             clr,
    input  logic [THRESH_W-1:0]              din,
    output logic [NUM_THRESH*THRESH_W-1:0]   shadow,
    output logic                             count_ok
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_THRESH);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(NUM_THRESH + 1);

    logic [CNT_W-1:0] count;

    // Newest word lands in slot 0; the descending send order leaves trig(d) at slot 2d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (shift) begin
            shadow <= {shadow[(NUM_THRESH-1)*THRESH_W-1:0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (shift && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign count_ok = (count == FULL);

endmodule

// File: rtl/beam_threshold_loader.sv
// Validates threshold-update frames and atomically commits trigger/subthreshold values for all beams.
module beam_threshold_loader
    import beam_threshold_loader_pkg::*;
#(
    parameter int NBEAMS = 46
) (
    input  logic                         aclk,
    input  logic                         rst_i,
    beam_threshold_loader_if.slave       bus,
    output logic [NBEAMS*THRESH_W-1:0]   trig_thresh_o,
    output logic [NBEAMS*THRESH_W-1:0]   sub_thresh_o,
    output logic                         commit_o,
    output logic                         err_o,
    output logic [1:0]                   err_code_o
);

    localparam int NDUAL      = ndualbeams(NBEAMS);
    localparam int NUM_THRESH = 2 * NDUAL;

    logic [1:0] wr;
    logic [1:0] up;
    logic       collide, lane_mis, upd_req, shift, clr_cnt, len_bad, commit_go;
    logic       ok0, ok1;
    logic [NUM_THRESH*THRESH_W-1:0] shadow0, shadow1;
    logic [NBEAMS*THRESH_W-1:0]     trig_next, sub_next;

    err_state_t state, state_nxt;
    err_code_t  code, code_nxt, new_err;

    assign wr = bus.thresh_wr_i;
    assign up = bus.thresh_update_i;

    assign collide   = (|wr) && (|up);
    assign lane_mis  = (wr == 2'b01) || (wr == 2'b10) || (up == 2'b01) || (up == 2'b10);
    assign upd_req   = (up == 2'b11) && (wr == 2'b00);
    assign shift     = (wr == 2'b11) && (up == 2'b00);
    assign commit_go = upd_req && ok0 && ok1;
    assign len_bad   = upd_req && !(ok0 && ok1);
    assign clr_cnt   = upd_req || lane_mis || collide;

    beam_threshold_loader_lane #(.NUM_THRESH(NUM_THRESH)) u_lane0 (
        .clk      (aclk),
        .rst      (rst_i),
        .shift    (shift),
        .clr      (clr_cnt),
        .din      (bus.thresh_i[THRESH_W-1:0]),
        .shadow   (shadow0),
        .count_ok (ok0)
    );

    beam_threshold_loader_lane #(.NUM_THRESH(NUM_THRESH)) u_lane1 (
        .clk      (aclk),
        .rst      (rst_i),
        .shift    (shift),
        .clr      (clr_cnt),
        .din      (bus.thresh_i[2*THRESH_W-1:THRESH_W]),
        .shadow   (shadow1),
        .count_ok (ok1)
    );

    always_comb begin
        new_err = ERR_NONE;
        if (collide)       new_err = ERR_COLLIDE;
        else if (lane_mis) new_err = ERR_LANE;
        else if (len_bad)  new_err = ERR_LEN;
    end

    // Sticky error: first code is held; a clear in the same cycle as a new error loses.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            ST_OK: begin
                if (new_err != ERR_NONE) begin
                    state_nxt = ST_ERR;
                    code_nxt  = new_err;
                end
            end
            ST_ERR: begin
                if (bus.err_clr_i) begin
                    if (new_err != ERR_NONE) begin
                        code_nxt = new_err;
                    end else begin
                        state_nxt = ST_OK;
                        code_nxt  = ERR_NONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_OK;
                code_nxt  = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_OK;
            code  <= ERR_NONE;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
        end
    end

    assign err_o      = (state == ST_ERR);
    assign err_code_o = code;

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        localparam int D = b / 2;
        logic [THRESH_W-1:0] trig_v, delta_v;
        if ((b % 2) == 0) begin : g_l0
            assign trig_v  = shadow0[(2*D)*THRESH_W +: THRESH_W];
            assign delta_v = shadow0[(2*D+1)*THRESH_W +: THRESH_W];
        end else begin : g_l1
            assign trig_v  = shadow1[(2*D)*THRESH_W +: THRESH_W];
            assign delta_v = shadow1[(2*D+1)*THRESH_W +: THRESH_W];
        end
        assign trig_next[b*THRESH_W +: THRESH_W] = trig_v;
        assign sub_next[b*THRESH_W +: THRESH_W]  = trig_v - delta_v;
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            trig_thresh_o <= {NBEAMS{DEFAULT_THRESH}};
            sub_thresh_o  <= {NBEAMS{DEFAULT_THRESH}};
            commit_o      <= 1'b0;
        end else begin
            commit_o <= commit_go;
            if (commit_go) begin
                trig_thresh_o <= trig_next;
                sub_thresh_o  <= sub_next;
            end
        end
    end

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Self-checking bench: drives frames and protocol faults, predicts commits/errors in a scoreboard.
module tb_beam_threshold_loader;
    import beam_threshold_loader_pkg::*;

    localparam int NB    = 46;
    localparam int NB45  = 45;
    localparam int NDUAL = 23;
    localparam int NUMT  = 46;
    localparam int CW    = NB * THRESH_W;
    localparam int CW45  = NB45 * THRESH_W;

    typedef struct packed {
        logic          commit;
        logic          err;
        logic [1:0]    code;
        logic [CW-1:0] trig;
        logic [CW-1:0] sub;
    } exp_t;

    logic aclk = 1'b0;
    logic rst  = 1'b1;

    beam_threshold_loader_if bus ();

    logic [CW-1:0]   trig46, sub46;
    logic [CW45-1:0] trig45, sub45;
    logic            commit46, commit45, err46, err45;
    logic [1:0]      code46, code45;

    beam_threshold_loader #(.NBEAMS(NB)) dut (
        .aclk          (aclk),
        .rst_i         (rst),
        .bus           (bus),
        .trig_thresh_o (trig46),
        .sub_thresh_o  (sub46),
        .commit_o      (commit46),
        .err_o         (err46),
        .err_code_o    (code46)
    );

    beam_threshold_loader #(.NBEAMS(NB45)) dut45 (
        .aclk          (aclk),
        .rst_i         (rst),
        .bus           (bus),
        .trig_thresh_o (trig45),
        .sub_thresh_o  (sub45),
        .commit_o      (commit45),
        .err_o         (err45),
        .err_code_o    (code45)
    );

    always #5 aclk = ~aclk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [THRESH_W-1:0] f_trig[NB];
    logic [THRESH_W-1:0] f_delta[NB];
    logic [THRESH_W-1:0] m_trig[NB];
    logic [THRESH_W-1:0] m_sub[NB];
    int                  cnt;
    logic                exp_err;
    logic [1:0]          exp_code;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] pack_trig();
        logic [CW-1:0] v;
        for (int b = 0; b < NB; b++) v[b*THRESH_W +: THRESH_W] = m_trig[b];
        return v;
    endfunction

    function automatic logic [CW-1:0] pack_sub();
        logic [CW-1:0] v;
        for (int b = 0; b < NB; b++) v[b*THRESH_W +: THRESH_W] = m_sub[b];
        return v;
    endfunction

    task automatic note_err(input logic [1:0] c);
        if (!exp_err) begin
            exp_err  = 1'b1;
            exp_code = c;
        end
    endtask

    task automatic model_clr();
        exp_err  = 1'b0;
        exp_code = 2'd0;
    endtask

    task automatic apply(input logic [1:0] wr, input logic [1:0] up,
                         input logic [THRESH_W-1:0] d0, input logic [THRESH_W-1:0] d1,
                         input logic clr);
        bus.thresh_i        = {d1, d0};
        bus.thresh_wr_i     = wr;
        bus.thresh_update_i = up;
        bus.err_clr_i       = clr;
        @(posedge aclk);
        #1;
        bus.thresh_i        = '0;
        bus.thresh_wr_i     = 2'b00;
        bus.thresh_update_i = 2'b00;
        bus.err_clr_i       = 1'b0;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        check({tag, "_commit"},   CW'(commit46), CW'(e.commit));
        check({tag, "_commit45"}, CW'(commit45), CW'(e.commit));
        check({tag, "_err"},      CW'(err46),    CW'(e.err));
        check({tag, "_code"},     CW'(code46),   CW'(e.code));
        check({tag, "_trig"},     trig46,        e.trig);
        check({tag, "_sub"},      sub46,         e.sub);
        check({tag, "_trig45"},   CW'(trig45),   CW'(e.trig[CW45-1:0]));
        check({tag, "_sub45"},    CW'(sub45),    CW'(e.sub[CW45-1:0]));
    endtask

    task automatic expect_now(input string tag, input logic commit);
        exp_t e;
        e.commit = commit;
        e.err    = exp_err;
        e.code   = exp_code;
        e.trig   = pack_trig();
        e.sub    = pack_sub();
        exp_q.push_back(e);
        compare_out(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b0;
        cnt = 0;
        model_clr();
        for (int b = 0; b < NB; b++) begin
            m_trig[b] = DEFAULT_THRESH;
            m_sub[b]  = DEFAULT_THRESH;
        end
    endtask

    task automatic load_vals(input int kind);
        for (int b = 0; b < NB; b++) begin
            case (kind)
                0: begin
                    f_trig[b]  = THRESH_W'(1000 + b / 2);
                    f_delta[b] = THRESH_W'(40);
                end
                1: begin
                    f_trig[b]  = THRESH_W'($urandom_range(0, 18'h3FFFF));
                    f_delta[b] = THRESH_W'($urandom_range(0, 18'h3FFFF));
                end
                default: begin
                    f_trig[b]  = THRESH_W'(5);
                    f_delta[b] = THRESH_W'(10);
                end
            endcase
        end
    endtask

    // Write k belongs to dual beam NDUAL-1-k/2: delta on even k, trig on odd k.
    task automatic send_frame(input int n);
        int d;
        for (int k = 0; k < n; k++) begin
            d = NDUAL - 1 - (k / 2) % NDUAL;
            if ((k % 2) == 0) apply(2'b11, 2'b00, f_delta[2*d], f_delta[2*d+1], 1'b0);
            else              apply(2'b11, 2'b00, f_trig[2*d],  f_trig[2*d+1],  1'b0);
            if (cnt < NUMT + 1) cnt++;
        end
    endtask

    task automatic do_update(input string tag);
        exp_t e;
        if (cnt == NUMT) begin
            for (int b = 0; b < NB; b++) begin
                m_trig[b] = f_trig[b];
                m_sub[b]  = f_trig[b] - f_delta[b];
            end
            e.commit = 1'b1;
        end else begin
            note_err(2'd1);
            e.commit = 1'b0;
        end
        cnt    = 0;
        e.err  = exp_err;
        e.code = exp_code;
        e.trig = pack_trig();
        e.sub  = pack_sub();
        exp_q.push_back(e);
        apply(2'b00, 2'b11, '0, '0, 1'b0);
        compare_out(tag);
    endtask

    task automatic clear_err(input string tag);
        apply(2'b00, 2'b00, '0, '0, 1'b1);
        model_clr();
        expect_now(tag, 1'b0);
    endtask

    initial begin
        bus.thresh_i        = '0;
        bus.thresh_wr_i     = 2'b00;
        bus.thresh_update_i = 2'b00;
        bus.err_clr_i       = 1'b0;

        do_reset();
        expect_now("reset", 1'b0);

        load_vals(0);
        send_frame(NUMT);
        do_update("full");
        check("b7_trig", CW'(trig46[7*THRESH_W +: THRESH_W]), CW'(18'd1003));
        check("b7_sub",  CW'(sub46[7*THRESH_W +: THRESH_W]),  CW'(18'd963));
        apply(2'b00, 2'b00, '0, '0, 1'b0);
        expect_now("idle_after_commit", 1'b0);

        load_vals(1);
        send_frame(NUMT - 1);
        do_update("short");
        clear_err("clr_len");
        send_frame(NUMT);
        do_update("after_clr");
        load_vals(1);
        send_frame(NUMT);
        do_update("back_to_back");

        load_vals(1);
        send_frame(20);
        apply(2'b01, 2'b00, 18'h12345, 18'h0ABCD, 1'b0);
        note_err(2'd2);
        cnt = 0;
        expect_now("lane_wr", 1'b0);
        send_frame(26);
        do_update("short_after_lane");
        clear_err("clr_lane");

        apply(2'b00, 2'b10, '0, '0, 1'b0);
        note_err(2'd2);
        cnt = 0;
        expect_now("lane_up", 1'b0);
        clear_err("clr_lane_up");

        send_frame(10);
        apply(2'b11, 2'b11, 18'h11111, 18'h22222, 1'b0);
        note_err(2'd3);
        cnt = 0;
        expect_now("collide", 1'b0);
        clear_err("clr_collide");

        apply(2'b10, 2'b00, '0, '0, 1'b1);
        note_err(2'd2);
        cnt = 0;
        expect_now("err_beats_clr", 1'b0);
        clear_err("clr_again");

        load_vals(1);
        send_frame(NUMT + 4);
        do_update("overlong");
        clear_err("clr_overlong");

        load_vals(1);
        send_frame(20);
        do_reset();
        send_frame(NUMT);
        do_update("post_reset");

        load_vals(2);
        send_frame(NUMT);
        do_update("wrap");
        check("wrap_b0_sub",   CW'(sub46[0 +: THRESH_W]), CW'(18'h3FFFB));
        check("wrap_b44_sub45", CW'(sub45[44*THRESH_W +: THRESH_W]), CW'(18'h3FFFB));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
